// File: rtl/dmem_access_unit.sv
// Load/store initiator: byte-addressed CPU requests to word accesses on a
// combinational-read data memory, with sub-word RMW and misalignment checks.
module dmem_access_unit #(
    parameter int DMEM_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int AW = DMEM_BITS + 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic          lat_write;
    logic [1:0]    lat_size;
    logic          lat_unsigned;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [31:0]   cap_word;

    logic          accept;
    logic          req_mis;
    logic          req_word_store;
    logic [31:0]   load_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          unused_addr_hi;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lsb[0];
            2'b10:   mis = |lsb;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    assign unused_addr_hi = ^req_addr[31:AW];

    assign accept         = req_valid && req_ready;
    assign req_mis        = is_misaligned(req_size, req_addr[1:0]);
    assign req_word_store = req_write && (req_size == 2'b10);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = {{(32 - DMEM_BITS){1'b0}}, lat_addr[AW-1:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_mis) begin
                        state_next = RESP;
                    end else if (req_word_store) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:  state_next = lat_write ? WRITE : RESP;
            WRITE: state_next = RESP;
            RESP:  state_next = IDLE;
        endcase
    end

    assign byte_sel = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
    assign half_sel = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        unique case (1'b1)
            (lat_size == 2'b00):
                load_data = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
            (lat_size == 2'b01):
                load_data = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
            default:
                load_data = mem_rdata;
        endcase
    end

    // Sub-word stores merge into the word captured during READ.
    always_comb begin
        mem_wdata = cap_word;
        unique case (1'b1)
            (lat_size == 2'b00):
                mem_wdata[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            (lat_size == 2'b01):
                mem_wdata[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default:
                mem_wdata = lat_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else if (accept) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr[AW-1:0];
            lat_wdata    <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_word <= '0;
        end else if (state == READ) begin
            cap_word <= mem_rdata;
        end
    end

    // Response fields only change on entry to RESP and hold afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            if (accept && req_mis) begin
                resp_rdata      <= '0;
                resp_misaligned <= 1'b1;
            end else if (state == READ && !lat_write) begin
                resp_rdata      <= load_data;
                resp_misaligned <= 1'b0;
            end else if (state == WRITE) begin
                resp_rdata      <= '0;
                resp_misaligned <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, reset and back-to-back
// sequences, then random traffic against a word-array memory model.
module tb_dmem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    int n_cmp;
    int n_fail;

    dmem_access_unit #(.DMEM_BITS(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic model_mis(input logic [1:0] sz,
                                       input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz,
                                               input logic u,
                                               input logic [31:0] a);
        longint word;
        longint span;
        longint v;
        int off;
        word = longint'(ref_mem[widx(a)]);
        off = int'(a % 4);
        if (sz == 2'd2) return ref_mem[widx(a)];
        span = (sz == 2'd0) ? 256 : 65536;
        v = (word >> (8 * off)) % span;
        if (!u && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic void model_store(input logic [1:0] sz,
                                        input logic [31:0] a,
                                        input logic [31:0] wd);
        int n;
        int off;
        int idx;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        idx = widx(a);
        for (int b = 0; b < n; b++)
            ref_mem[idx][8 * (off + b) +: 8] = wd[8 * b +: 8];
    endfunction

    task automatic run_req(input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a,
                           input logic [31:0] wd,
                           output logic [31:0] rd, output logic mis,
                           output int lat, output int we_cnt,
                           output logic pulse_ok, output logic addr_ok);
        logic [31:0] want_addr;
        want_addr = 32'(widx(a));
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        lat = 0;
        we_cnt = 0;
        addr_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                lat = k;
                break;
            end
            if (mem_addr !== want_addr) addr_ok = 1'b0;
        end
        rd  = resp_rdata;
        mis = resp_misaligned;
        @(negedge clk);
        pulse_ok = !resp_valid && req_ready && (resp_rdata === rd);
    endtask

    task automatic check_req(input string name, input logic w,
                             input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_mis,
                             input int exp_lat);
        logic [31:0] rd;
        logic mis;
        int lat;
        int we_cnt;
        logic pulse_ok;
        logic addr_ok;
        run_req(w, sz, u, a, wd, rd, mis, lat, we_cnt, pulse_ok, addr_ok);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " misaligned"}, 32'(mis), 32'(exp_mis));
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " we_cycles"}, 32'(we_cnt), 32'(w && !exp_mis));
        check({name, " pulse"}, 32'(pulse_ok), 32'd1);
        check({name, " mem_addr"}, 32'(addr_ok), 32'd1);
        if (w && !exp_mis) model_store(sz, a, wd);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        int          lat;
    } vec_t;

    vec_t vt[16];

    task automatic interrupt_store(input string name, input logic [1:0] sz,
                                   input logic [31:0] a, input logic exp_we);
        logic quiet;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = sz;
        req_addr  = a;
        req_wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        check({name, " we_before"}, 32'(mem_we), 32'(exp_we));
        reset = 1'b1;
        #1;
        check({name, " we_async"}, 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid || !req_ready || mem_we) quiet = 1'b0;
        end
        check({name, " idle_after"}, 32'(quiet), 32'd1);
    endtask

    initial begin
        logic [31:0] addrs [3];
        logic [31:0] exps [3];
        int issued;
        int got;
        int last_c;
        logic prev_resp;
        int diffs;

        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset resp", {29'd0, resp_valid, resp_misaligned, mem_we}, 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2};
        vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2};
        vt[3]  = '{1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3};
        vt[4]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2};
        vt[5]  = '{1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F00, 32'h0, 1'b0, 2};
        vt[6]  = '{1'b0, 2'd0, 1'b0, 32'h33, 32'h0, 32'hFFFFFF80, 1'b0, 2};
        vt[7]  = '{1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 32'h00000080, 1'b0, 2};
        vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 32'hFFFF80FF, 1'b0, 2};
        vt[9]  = '{1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1, 1};
        vt[10] = '{1'b1, 2'd2, 1'b0, 32'h32, 32'h12345678, 32'h0, 1'b1, 1};
        vt[11] = '{1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1};
        vt[12] = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h80FF7F00, 1'b0, 2};
        vt[13] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFE1234, 32'h0, 1'b0, 3};
        vt[14] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0, 2};
        vt[15] = '{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 32'h1234BEEF, 1'b0, 2};

        for (int i = 0; i < 16; i++) begin
            check_req($sformatf("vec%0d", i), vt[i].w, vt[i].sz, vt[i].u,
                      vt[i].a, vt[i].wd, vt[i].rd, vt[i].mis, vt[i].lat);
        end

        interrupt_store("rst_write", 2'd2, 32'h40, 1'b1);
        interrupt_store("rst_read", 2'd0, 32'h41, 1'b0);
        check_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0,
                  ref_mem[16], 1'b0, 2);

        addrs[0] = 32'h10;
        addrs[1] = 32'h20;
        addrs[2] = 32'h30;
        for (int i = 0; i < 3; i++) exps[i] = model_load(2'd2, 1'b0, addrs[i]);
        issued = 0;
        got = 0;
        last_c = 0;
        prev_resp = 1'b0;
        req_write = 1'b0;
        req_size = 2'd2;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                check($sformatf("b2b%0d rdata", got), resp_rdata, exps[got]);
                if (got > 0)
                    check($sformatf("b2b%0d spacing", got), 32'(c - last_c), 32'd3);
                check($sformatf("b2b%0d single", got), 32'(prev_resp), 32'd0);
                last_c = c;
                got++;
            end
            prev_resp = resp_valid;
            if (req_ready) begin
                if (issued < 3) begin
                    req_valid = 1'b1;
                    req_addr = addrs[issued];
                    issued++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b count", 32'(got), 32'd3);
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            logic w;
            logic [1:0] sz;
            logic u;
            logic [31:0] a;
            logic [31:0] wd;
            logic mis;
            logic [31:0] erd;
            int elat;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
            wd = $urandom;
            mis = model_mis(sz, a);
            erd = (w || mis) ? 32'd0 : model_load(sz, u, a);
            elat = mis ? 1 : (w && sz != 2'd2) ? 3 : 2;
            check_req($sformatf("rnd%0d", i), w, sz, u, a, wd, erd, mis, elat);
        end

        diffs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        check("memory image diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
